ram_port_scheduler: RTL
=======================

# ram_port_scheduler

Clocked, synthesizable responder for the CPU's RAM request/ready protocol. It sits between the three stage initiators and the single-port synchronous `ram`:
- stage12: instruction fetch read.
- stage3: data read.
- stage5: data save.

It arbitrates with fixed priority plus a store-aging guard. It serialises accesses onto the RAM port and completes each request with a four-phase handshake.

## Interface
Parameters:
- ADDR_W, 16, RAM address width
- DATA_W, 8, RAM data width
- STORE_AGE_MAX, 4, number of consecutive lost arbitrations after which a pending stage5 save wins (1..15)

Ports (all widths in bits):
- ram_clk  in  1  sole clock; all state changes on its rising edge
- rst  in  1  asynchronous, active-high reset
- stage12_read  in  1  fetch read request (level)
- stage12_read_address  in  ADDR_W  fetch read address
- stage12_read_ready  out  1  fetch completion
- stage12_read_data_out  out  DATA_W  fetch read data
- stage3_read  in  1  data read request (level)
- stage3_read_address  in  ADDR_W  data read address
- stage3_read_ready  out  1  data read completion
- stage3_read_data_out  out  DATA_W  data read data
- stage5_save  in  1  save request (level)
- stage5_save_address  in  ADDR_W  save address
- stage5_save_data_in  in  DATA_W  save data
- stage5_save_ready  out  1  save completion
- ram_write_enable  out  1  to ram.write_enable
- ram_address  out  ADDR_W  to ram.address
- ram_data_in  out  DATA_W  to ram.data_in
- ram_data_out  in  DATA_W  from ram.data_out (registered inside the RAM, one-cycle read latency)
- grant_id  out  2  client currently being served: 0 = none, 1 = stage12, 2 = stage3, 3 = stage5

## Operation
- **Reset.** While rst is high, all outputs and state are 0: state IDLE, ready flags 0, data_out registers 0, ram_* 0, grant_id 0, age counter 0.
- **FSM.** Four states: IDLE, ISSUE, CAPTURE, ACK.
- **IDLE.** If any request is high, grant one client and latch its address (and data, for a save) into ram_address/ram_data_in.
  - ram_write_enable is set to 1 only for a stage5 grant.
  - grant_id is set, and the state moves to ISSUE.
  - With no request, stay in IDLE.
- **Priority.** stage3 > stage12 > stage5.
  - Exception: if stage5_save is high and age == STORE_AGE_MAX, stage5 wins.
- **Age counter (4 bits).**
  - Increments, saturating at STORE_AGE_MAX, on each grant to stage3 or stage12 while stage5_save is high.
  - Clears on a stage5 grant.
  - Clears on any edge where stage5_save is low.
- **ISSUE.** The RAM samples the address (and performs the write) at this edge. ram_write_enable returns to 0 and the state moves to CAPTURE.
- **CAPTURE.**
  - For a read, copy ram_data_out into the granted client's data_out register.
  - Set the granted client's ready to 1 and move to ACK.
- **ACK.** Hold ready high until the granted request is sampled low. On that edge:
  - ready returns to 0,
  - grant_id returns to 0,
  - the state moves to IDLE.
- **Data hold.** Each data_out register holds its value until the next completed read for that client.
- **Latched requests.** Address and data are latched at grant. Input changes during ISSUE, CAPTURE or ACK are ignored.
- **Early request drop.** If a client drops its request before ready rises, the access still completes. ready is then high for exactly one cycle, because ACK sees the request low on its first edge.
- **Requests from other clients** stay pending and are not acknowledged until they are granted.

## Timing
- **Edge numbering.** Request sampled high in IDLE at edge E:
  - ram_address is valid after E,
  - the RAM read/write happens at E+1,
  - ready rises after E+2.
- **Read data** is valid on data_out no later than the edge where ready rises.
- **Release.** Request sampled low at edge F, where F ≥ E+3: ready falls after F, and IDLE can grant again at F+1.
- **Throughput.** Back-to-back throughput is 1 access per 4 cycles minimum when the initiator drops its request immediately.
- **Reset mid-operation.** Assertion takes effect immediately (asynchronous).
  - A save whose edge E+1 has already passed stays committed.
  - A save reset before edge E+1 is not performed.
  - Initiators must re-request after reset.
- **Simultaneous requests at IDLE** are resolved by the priority and age rules in a single edge. There are no idle cycles between grants beyond the one-cycle ACK→IDLE step.

## Test plan
- **Single fetch.** RAM[0x0010] = 0xA5; raise stage12_read with address 0x0010. Required: stage12_read_ready rises 3 edges later with data_out = 0xA5; it falls one edge after the request drops.
- **Save then read back.** stage5 saves 0x3C to 0x0100; then stage3 reads 0x0100. Required: ram_write_enable is high for exactly one cycle; stage3_read_data_out = 0x3C.
- **Simultaneous requests.** All three requests raised on the same edge, each dropped on its ready. Required: grant order is stage3, stage12, stage5; grant_id sequence is 2, 1, 3.
- **Aging.** With STORE_AGE_MAX = 4, hold stage5_save high while stage3 re-requests continuously. Required: stage5 is granted after exactly 4 stage3 grants, and the age counter then reads 0.
- **Early drop.** stage3 drops its request one cycle after raising it. Required: the read completes and stage3_read_ready is high for exactly 1 cycle.
- **Reset mid-save.** Assert rst in the cycle after a stage5 grant, before edge E+1. Required: all outputs are 0 immediately and RAM contents are unchanged.

Source files
------------

// File: rtl/ram_port_scheduler.sv
// ============================================================================
// Module      : ram_port_scheduler
// Description : Arbitrates fetch-read, data-read and data-save requests onto a
//               single-port synchronous RAM.  Fixed priority with a store-aging
//               guard; each access completes with a four-phase request/ready
//               handshake (IDLE -> ISSUE -> CAPTURE -> ACK).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ram_port_scheduler #(
    parameter int ADDR_W        = 16,
    parameter int DATA_W        = 8,
    parameter int STORE_AGE_MAX = 4
) (
    input  logic              ram_clk,
    input  logic              rst,
    input  logic              stage12_read,
    input  logic [ADDR_W-1:0] stage12_read_address,
    output logic              stage12_read_ready,
    output logic [DATA_W-1:0] stage12_read_data_out,
    input  logic              stage3_read,
    input  logic [ADDR_W-1:0] stage3_read_address,
    output logic              stage3_read_ready,
    output logic [DATA_W-1:0] stage3_read_data_out,
    input  logic              stage5_save,
    input  logic [ADDR_W-1:0] stage5_save_address,
    input  logic [DATA_W-1:0] stage5_save_data_in,
    output logic              stage5_save_ready,
    output logic              ram_write_enable,
    output logic [ADDR_W-1:0] ram_address,
    output logic [DATA_W-1:0] ram_data_in,
    input  logic [DATA_W-1:0] ram_data_out,
    output logic [1:0]        grant_id
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        CAPTURE = 2'd2,
        ACK     = 2'd3
    } state_t;

    localparam logic [1:0] c_GNT_NONE    = 2'd0;
    localparam logic [1:0] c_GNT_STAGE12 = 2'd1;
    localparam logic [1:0] c_GNT_STAGE3  = 2'd2;
    localparam logic [1:0] c_GNT_STAGE5  = 2'd3;
    localparam logic [3:0] c_AGE_MAX     = 4'(STORE_AGE_MAX);

    state_t            r_state;
    state_t            w_state_next;
    logic [1:0]        r_grant;
    logic [1:0]        w_pick;
    logic              w_granted_req;
    logic [3:0]        r_age;
    logic              r_we;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic              r_rdy12;
    logic              r_rdy3;
    logic              r_rdy5;
    logic [DATA_W-1:0] r_data12;
    logic [DATA_W-1:0] r_data3;

    // Arbitration: an aged pending save beats everything, otherwise stage3 > stage12 > stage5
    always_comb begin
        w_pick = c_GNT_NONE;
        if (stage5_save && (r_age == c_AGE_MAX)) begin
            w_pick = c_GNT_STAGE5;
        end else if (stage3_read) begin
            w_pick = c_GNT_STAGE3;
        end else if (stage12_read) begin
            w_pick = c_GNT_STAGE12;
        end else if (stage5_save) begin
            w_pick = c_GNT_STAGE5;
        end
    end

    // Live request level of the client currently holding the grant (used to release ACK)
    always_comb begin
        w_granted_req = 1'b0;
        case (r_grant)
            c_GNT_STAGE12: w_granted_req = stage12_read;
            c_GNT_STAGE3:  w_granted_req = stage3_read;
            c_GNT_STAGE5:  w_granted_req = stage5_save;
            default:       w_granted_req = 1'b0;
        endcase
    end

    // State register
    always_ff @(posedge ram_clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic: fixed three-cycle access followed by a handshake wait
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (w_pick != c_GNT_NONE) w_state_next = ISSUE;
            ISSUE:   w_state_next = CAPTURE;
            CAPTURE: w_state_next = ACK;
            ACK:     if (!w_granted_req) w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    // Datapath: latch the granted request, drive the RAM port, capture read data and ready
    always_ff @(posedge ram_clk or posedge rst) begin
        if (rst) begin
            r_grant  <= c_GNT_NONE;
            r_we     <= 1'b0;
            r_addr   <= '0;
            r_wdata  <= '0;
            r_rdy12  <= 1'b0;
            r_rdy3   <= 1'b0;
            r_rdy5   <= 1'b0;
            r_data12 <= '0;
            r_data3  <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_pick != c_GNT_NONE) begin
                        r_grant <= w_pick;
                        r_we    <= (w_pick == c_GNT_STAGE5);
                        case (w_pick)
                            c_GNT_STAGE12: r_addr <= stage12_read_address;
                            c_GNT_STAGE3:  r_addr <= stage3_read_address;
                            default: begin
                                r_addr  <= stage5_save_address;
                                r_wdata <= stage5_save_data_in;
                            end
                        endcase
                    end
                end
                ISSUE: begin
                    // The RAM has sampled address/write at this edge; write is one cycle only
                    r_we <= 1'b0;
                end
                CAPTURE: begin
                    case (r_grant)
                        c_GNT_STAGE12: begin
                            r_data12 <= ram_data_out;
                            r_rdy12  <= 1'b1;
                        end
                        c_GNT_STAGE3: begin
                            r_data3 <= ram_data_out;
                            r_rdy3  <= 1'b1;
                        end
                        c_GNT_STAGE5: r_rdy5 <= 1'b1;
                        default: ;
                    endcase
                end
                ACK: begin
                    if (!w_granted_req) begin
                        r_rdy12 <= 1'b0;
                        r_rdy3  <= 1'b0;
                        r_rdy5  <= 1'b0;
                        r_grant <= c_GNT_NONE;
                    end
                end
                default: ;
            endcase
        end
    end

    // Store-aging counter: counts reads granted over a waiting save, saturating at the limit
    always_ff @(posedge ram_clk or posedge rst) begin
        if (rst) begin
            r_age <= 4'd0;
        end else if (!stage5_save) begin
            r_age <= 4'd0;
        end else if (r_state == IDLE) begin
            if (w_pick == c_GNT_STAGE5) begin
                r_age <= 4'd0;
            end else if ((w_pick != c_GNT_NONE) && (r_age != c_AGE_MAX)) begin
                r_age <= r_age + 4'd1;
            end
        end
    end

    assign stage12_read_ready    = r_rdy12;
    assign stage12_read_data_out = r_data12;
    assign stage3_read_ready     = r_rdy3;
    assign stage3_read_data_out  = r_data3;
    assign stage5_save_ready     = r_rdy5;
    assign ram_write_enable      = r_we;
    assign ram_address           = r_addr;
    assign ram_data_in           = r_wdata;
    assign grant_id              = r_grant;

endmodule

`default_nettype wire
